llr_load_ctrl: RTL and testbench

//  Sequences the channel-LLR quantizer: streams Q5.11 channel samples into it, packs the

---
 rtl/llr_load_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_llr_load_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_load_ctrl.sv
// Channel-LLR load sequencer: streams samples through the external quantizer, packs LLRs
// PAR-wide into a ping-pong channel memory and hands full banks to the decoder.
// Optional LLR_STATS_EN adds sat_count (saturated LLRs in the last completed frame).
module llr_load_ctrl #(
   parameter int unsigned DATA_W    = 5,
   parameter int unsigned FRAME_LEN = 648,
   parameter int unsigned PAR       = 8,
   parameter int unsigned ADDR_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [3:0]              cfg_snr_idx,
   input  logic [4:0]              cfg_frac_w,
   output logic                    busy,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [15:0]             in_data,
   output logic [3:0]              q_snr_idx,
   output logic [4:0]              q_frac_w,
   output logic [15:0]             q_data,
   input  logic [DATA_W-1:0]       q_llr,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [PAR*DATA_W-1:0]   mem_wdata,
   output logic                    dec_start,
   output logic                    dec_bank,
   input  logic                    dec_release,
   input  logic                    dec_release_bank,
   output logic [1:0]              bank_full
`ifdef LLR_STATS_EN
   ,
   output logic [15:0]             sat_count
`endif
);

   localparam int unsigned WORDS  = FRAME_LEN / PAR;
   localparam int unsigned LANE_W = (PAR > 1) ? $clog2(PAR) : 1;
   localparam int unsigned WIDX_W = ADDR_W - 1;
   localparam int unsigned SAMP_W = $clog2(FRAME_LEN + 1);
   localparam logic [DATA_W-1:0] SAT_POS = DATA_W'((1 << (DATA_W - 1)) - 1);
   localparam logic [DATA_W-1:0] SAT_NEG = DATA_W'(1 << (DATA_W - 1));

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              snr_q, snr_d;
   logic [4:0]              frac_q, frac_d;
   logic [15:0]             qd_q, qd_d;
   logic                    qv_q, qv_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [WIDX_W-1:0]       word_q, word_d;
   logic [SAMP_W-1:0]       samp_q, samp_d;
   logic [PAR*DATA_W-1:0]   pack_q, pack_d;
   logic                    we_q, we_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [PAR*DATA_W-1:0]   wdata_q, wdata_d;
   logic                    dst_q, dst_d;
   logic                    dbank_q, dbank_d;
   logic                    wr_bank_q, wr_bank_d;
   logic [1:0]              full_q, full_d;
   logic [15:0]             sat_frame_q, sat_frame_d;
   logic [15:0]             sat_q, sat_d;

   logic                    accept;
   logic                    last_lane;
   logic                    last_wr;

   assign accept    = (state_q == S_LOAD) && in_valid;
   assign last_lane = (lane_q == LANE_W'(PAR - 1));
   assign last_wr   = qv_q && last_lane && (word_q == WIDX_W'(WORDS - 1));

   always_comb begin
      state_d     = state_q;
      snr_d       = snr_q;
      frac_d      = frac_q;
      qd_d        = qd_q;
      qv_d        = 1'b0;
      lane_d      = lane_q;
      word_d      = word_q;
      samp_d      = samp_q;
      pack_d      = pack_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      dst_d       = 1'b0;
      dbank_d     = dbank_q;
      wr_bank_d   = wr_bank_q;
      full_d      = full_q;
      sat_frame_d = sat_frame_q;
      sat_d       = sat_q;

      if (accept) begin
         qd_d   = in_data;
         qv_d   = 1'b1;
         samp_d = samp_q + SAMP_W'(1);
      end

      // Quantizer output for the sample registered last cycle lands in its lane
      if (qv_q) begin
         for (int k = 0; k < int'(PAR); k++) begin
            if (lane_q == LANE_W'(k)) pack_d[k*DATA_W +: DATA_W] = q_llr;
         end
         if (((q_llr == SAT_POS) || (q_llr == SAT_NEG)) && (sat_frame_q != 16'hFFFF))
            sat_frame_d = sat_frame_q + 16'd1;
         if (last_lane) begin
            lane_d  = '0;
            we_d    = 1'b1;
            addr_d  = {wr_bank_q, word_q};
            wdata_d = pack_d;
            word_d  = word_q + WIDX_W'(1);
         end else begin
            lane_d = lane_q + LANE_W'(1);
         end
      end

      if (dec_release) full_d[dec_release_bank] = 1'b0;

      // Frame complete: fill overrides a same-cycle release of the same bank
      if (last_wr) begin
         dst_d             = 1'b1;
         dbank_d           = wr_bank_q;
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
         lane_d            = '0;
         word_d            = '0;
         samp_d            = '0;
         sat_d             = sat_frame_d;
         sat_frame_d       = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               snr_d   = cfg_snr_idx;
               frac_d  = cfg_frac_w;
               state_d = full_q[wr_bank_q] ? S_WAIT : S_LOAD;
            end
         end
         S_WAIT: begin
            if (!full_q[wr_bank_q]) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (accept && (samp_q == SAMP_W'(FRAME_LEN - 1))) begin
               state_d = S_DRAIN;
               samp_d  = '0;
            end
         end
         S_DRAIN: begin
            if (last_wr) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         snr_q       <= '0;
         frac_q      <= '0;
         qd_q        <= '0;
         qv_q        <= 1'b0;
         lane_q      <= '0;
         word_q      <= '0;
         samp_q      <= '0;
         pack_q      <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         dst_q       <= 1'b0;
         dbank_q     <= 1'b0;
         wr_bank_q   <= 1'b0;
         full_q      <= '0;
         sat_frame_q <= '0;
         sat_q       <= '0;
      end else begin
         state_q     <= state_d;
         snr_q       <= snr_d;
         frac_q      <= frac_d;
         qd_q        <= qd_d;
         qv_q        <= qv_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         samp_q      <= samp_d;
         pack_q      <= pack_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         dst_q       <= dst_d;
         dbank_q     <= dbank_d;
         wr_bank_q   <= wr_bank_d;
         full_q      <= full_d;
         sat_frame_q <= sat_frame_d;
         sat_q       <= sat_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign in_ready  = (state_q == S_LOAD);
   assign q_snr_idx = snr_q;
   assign q_frac_w  = frac_q;
   assign q_data    = qd_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign dec_start = dst_q;
   assign dec_bank  = dbank_q;
   assign bank_full = full_q;
`ifdef LLR_STATS_EN
   assign sat_count = sat_q;
`else
   logic unused_sat;
   assign unused_sat = ^{sat_q, sat_frame_q};
`endif

endmodule

// File: tb/tb_llr_load_ctrl.sv
// Scoreboard bench for llr_load_ctrl with a behavioural quantizer in the loop.
module tb_llr_load_ctrl;
   localparam int unsigned DW  = 5;
   localparam int unsigned FL  = 16;
   localparam int unsigned PAR = 4;
   localparam int unsigned AW  = 3;

   logic              clk, rst, start;
   logic [3:0]        cfg_snr_idx;
   logic [4:0]        cfg_frac_w;
   logic              busy, in_valid, in_ready;
   logic [15:0]       in_data;
   logic [3:0]        q_snr_idx;
   logic [4:0]        q_frac_w;
   logic [15:0]       q_data;
   logic [DW-1:0]     q_llr;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [PAR*DW-1:0] mem_wdata;
   logic              dec_start, dec_bank, dec_release, dec_release_bank;
   logic [1:0]        bank_full;
`ifdef LLR_STATS_EN
   logic [15:0]       sat_count;
`endif

   llr_load_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .PAR(PAR), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_snr_idx(cfg_snr_idx),
      .cfg_frac_w(cfg_frac_w), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .q_snr_idx(q_snr_idx), .q_frac_w(q_frac_w), .q_data(q_data),
      .q_llr(q_llr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .dec_start(dec_start), .dec_bank(dec_bank), .dec_release(dec_release),
      .dec_release_bank(dec_release_bank), .bank_full(bank_full)
`ifdef LLR_STATS_EN
      , .sat_count(sat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Quantizer model: scale by (snr+1), shift down to frac_w fractional bits, saturate
   function automatic logic [DW-1:0] qfn(input logic [15:0] d, input logic [3:0] s,
                                         input logic [4:0] f);
      int v, sh;
      sh = 11 - int'($signed(f));
      if (sh < 0) sh = 0;
      if (sh > 20) sh = 20;
      v = int'($signed(d)) * (int'(s) + 1);
      v = v >>> sh;
      if (v > 15) v = 15;
      if (v < -16) v = -16;
      return DW'(v);
   endfunction

   always_comb q_llr = qfn(q_data, q_snr_idx, q_frac_w);

   typedef struct {
      logic [AW-1:0]     addr;
      logic [PAR*DW-1:0] wdata;
      logic              dec;
   } wr_t;

   wr_t         sb[$];
   wr_t         mon_e;
   int          total = 0;
   int          bad = 0;
   int          m_bank;
   logic [1:0]  m_full;
   int          m_sat;
   logic [15:0] smp[FL];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: addr %0h data %0h (t=%0t)", mem_addr, mem_wdata, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
            chk("dec_start", 32'(dec_start), 32'(mon_e.dec));
            if (mon_e.dec) chk("dec_bank", 32'(dec_bank), 32'(mon_e.addr[AW-1]));
         end
      end else if (dec_start) begin
         total++; bad++;
         $display("FAIL stray_dec_start: got 1 expected 0 (t=%0t)", $time);
      end
   end

   // Expected writes for the words completed by nfeed samples; full frame fills the bank
   task automatic push_frame(input int nfeed, input logic [3:0] s, input logic [4:0] f);
      wr_t         e;
      logic [DW-1:0] l;
      int          ns;
      ns = 0;
      for (int w = 0; w < int'(FL / PAR); w++) begin
         for (int k = 0; k < int'(PAR); k++) begin
            l = qfn(smp[w*PAR + k], s, f);
            e.wdata[k*DW +: DW] = l;
            if (l == 5'b01111 || l == 5'b10000) ns++;
         end
         e.addr = AW'((m_bank << (AW - 1)) + w);
         e.dec  = (w == int'(FL / PAR) - 1);
         if ((w + 1) * int'(PAR) <= nfeed) sb.push_back(e);
      end
      if (nfeed == int'(FL)) begin
         m_sat = ns;
         m_full[m_bank] = 1'b1;
         m_bank ^= 1;
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input logic [3:0] s, input logic [4:0] f);
      cfg_snr_idx = s; cfg_frac_w = f; start = 1'b1;
      tick();
      start = 1'b0;
      cfg_snr_idx = 4'($urandom); cfg_frac_w = 5'($urandom);
   endtask

   task automatic feed(input int nmax, input bit gap, input bit poke);
      int cyc; int idx; bit ph; bit poked; bit v;
      cyc = 0; idx = 0; ph = 1'b1; poked = 1'b0;
      while (idx < nmax && cyc < 400) begin
         v = gap ? ph : 1'b1;
         ph = ~ph;
         in_valid = v;
         in_data  = smp[idx];
         start    = poke && (idx == 6) && !poked;
         if (start) begin poked = 1'b1; cfg_snr_idx = 4'd9; end
         @(negedge clk);
         if (v && in_ready) idx++;
         tick();
         cyc++;
      end
      in_valid = 1'b0; start = 1'b0;
      if (cyc >= 400) begin
         total++; bad++;
         $display("FAIL feed_timeout: got %0d samples expected %0d", idx, nmax);
      end
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (busy && c < 50) begin tick(); c++; end
      if (c >= 50) begin
         total++; bad++;
         $display("FAIL idle_timeout: got busy expected idle");
      end
      repeat (3) tick();
      chk("bank_full", 32'(bank_full), 32'(m_full));
`ifdef LLR_STATS_EN
      chk("sat_count", 32'(sat_count), 32'(m_sat));
`endif
   endtask

   task automatic release_bank(input logic b);
      dec_release = 1'b1; dec_release_bank = b;
      tick();
      dec_release = 1'b0;
      m_full[b] = 1'b0;
   endtask

   task automatic rand_smp();
      for (int i = 0; i < int'(FL); i++) smp[i] = 16'($urandom);
   endtask

   task automatic frame(input logic [3:0] s, input logic [4:0] f, input bit gap);
      do_start(s, f);
      push_frame(FL, s, f);
      feed(FL, gap, 1'b0);
      @(negedge clk);
      chk("in_ready_after_last", 32'(in_ready), 32'd0);
      tick();
      wait_idle();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_snr_idx = '0; cfg_frac_w = '0;
      in_valid = 1'b0; in_data = '0; dec_release = 1'b0; dec_release_bank = 1'b0;
      m_bank = 0; m_full = 2'b00; m_sat = 0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_bank_full", 32'(bank_full), 32'd0);
      chk("rst_q_data", 32'(q_data), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Back-to-back frame into bank 0, then the same samples with in_valid toggling
      rand_smp();
      frame(4'd0, 5'd2, 1'b0);
      release_bank(1'b0);
      frame(4'd0, 5'd2, 1'b1);
      release_bank(1'b1);

      // Fill both banks, third start must wait for a release
      rand_smp(); frame(4'd3, 5'd4, 1'b0);
      rand_smp(); frame(4'd1, 5'd1, 1'b1);
      do_start(4'd0, 5'd3);
      repeat (3) begin
         @(negedge clk);
         chk("wait_in_ready", 32'(in_ready), 32'd0);
         chk("wait_busy", 32'(busy), 32'd1);
         tick();
      end
      release_bank(1'b0);
      @(negedge clk);
      chk("release_in_ready_0", 32'(in_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("release_in_ready_1", 32'(in_ready), 32'd1);
      tick();
      rand_smp();
      push_frame(FL, 4'd0, 5'd3);
      feed(FL, 1'b0, 1'b1);
      chk("q_snr_idx_held", 32'(q_snr_idx), 32'd0);
      wait_idle();

      // Start and release of the write bank in the same cycle
      cfg_snr_idx = 4'd5; cfg_frac_w = 5'd2; start = 1'b1;
      dec_release = 1'b1; dec_release_bank = 1'b1;
      tick();
      start = 1'b0; dec_release = 1'b0; m_full[1] = 1'b0;
      cfg_snr_idx = 4'd0;
      @(negedge clk);
      chk("sr_in_ready_0", 32'(in_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("sr_in_ready_1", 32'(in_ready), 32'd1);
      tick();
      rand_smp();
      push_frame(FL, 4'd5, 5'd2);
      feed(FL, 1'b1, 1'b0);
      wait_idle();
      release_bank(1'b0);
      release_bank(1'b1);

      // Reset after 6 samples: only word 0 is written
      rand_smp();
      do_start(4'd2, 5'd3);
      push_frame(6, 4'd2, 5'd3);
      feed(6, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_bank = 0; m_full = 2'b00; m_sat = 0;
      repeat (6) tick();
      @(negedge clk);
      chk("midrst_bank_full", 32'(bank_full), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      tick();
      rand_smp(); frame(4'd7, 5'd5, 1'b0);
      release_bank(1'b0);

      // Saturating frame
      for (int i = 0; i < int'(FL); i++) smp[i] = 16'h7FFF;
      frame(4'd0, 5'd2, 1'b0);
      release_bank(1'b1);

      for (int n = 0; n < 4; n++) begin
         rand_smp();
         frame(4'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
         release_bank(1'(1 - m_bank));
      end

      repeat (5) tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
